// File: rtl/disp_wta_decode_if.sv
// disp_wta_decode_if: packed-word input stream and disparity/cost result stream
interface disp_wta_decode_if #(parameter int DW = 8);
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [8:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] disp_out;
  logic [4:0]    cost_out;
  modport master(output in_valid, in_sof, in_data, out_ready,
                 input  in_ready, out_valid, disp_out, cost_out);
  modport slave(input  in_valid, in_sof, in_data, out_ready,
                output in_ready, out_valid, disp_out, cost_out);
endinterface

// File: rtl/disp_wta_decode.sv
// disp_wta_decode: reduces per-chunk comparator winner words into one WTA disparity per pixel.
// Define DISP_COST_CHECK_EN to mark results whose cost exceeds MAX_COST with an all-ones disparity.
module disp_wta_decode #(
  parameter int         CHUNKS   = 16,
  parameter int         DW       = 8,
  parameter logic [4:0] MAX_COST = 5'd24
) (
  input logic               clk,
  input logic               rst,
  disp_wta_decode_if.slave  bus
);
  localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);
`ifdef DISP_COST_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  typedef enum logic {IDLE, ACC} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [4:0]    best_cost_q, best_cost_d;
  logic [DW-1:0] best_disp_q, best_disp_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [4:0]    cost_q, cost_d;
  logic          accept, last, better;
  logic [CW-1:0] chunk;
  logic [4:0]    cost, win_cost;
  logic [DW-1:0] cand, win_disp;
  logic          unused_rsvd;
  assign unused_rsvd   = ^bus.in_data[8:7];
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.disp_out  = disp_q;
  assign bus.cost_out  = cost_q;
  always_comb begin
    accept      = bus.in_valid && bus.in_ready;
    chunk       = bus.in_sof ? '0 : chunk_cnt_q;
    last        = chunk == LAST;
    cost        = bus.in_data[6:2];
    cand        = DW'({chunk, bus.in_data[0], bus.in_data[1]});
    // a pixel's first beat (IDLE or sof restart) always wins; later beats need strictly lower cost
    better      = bus.in_sof || state_q == IDLE || cost < best_cost_q;
    win_cost    = better ? cost : best_cost_q;
    win_disp    = better ? cand : best_disp_q;
    state_d     = accept ? (last ? IDLE : ACC) : state_q;
    chunk_cnt_d = accept ? (last ? '0 : chunk + CW'(1)) : chunk_cnt_q;
    best_cost_d = accept ? win_cost : best_cost_q;
    best_disp_d = accept ? win_disp : best_disp_q;
    out_valid_d = (accept && last) || (out_valid_q && !bus.out_ready);
    cost_d      = (accept && last) ? win_cost : cost_q;
    disp_d      = (accept && last) ? ((CHECK && win_cost > MAX_COST) ? '1 : win_disp) : disp_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      chunk_cnt_q <= '0;
      best_cost_q <= 5'h1F;
      best_disp_q <= '0;
      out_valid_q <= 1'b0;
      disp_q      <= '0;
      cost_q      <= '0;
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      best_cost_q <= best_cost_d;
      best_disp_q <= best_disp_d;
      out_valid_q <= out_valid_d;
      disp_q      <= disp_d;
      cost_q      <= cost_d;
    end
  end
endmodule

// File: doc/disp_wta_decode.md
# disp_wta_decode

Decodes the packed 9-bit winner words produced by the 4-way cost comparator stage and reduces them across a pixel's disparity chunks. Each pixel's disparity range is presented as CHUNKS consecutive words, one per group of four candidates. The block recovers each word's minimum cost and local index, keeps a running winner-take-all minimum, and emits one disparity plus its cost per pixel over a valid/ready interface. It sits between the comparator tree and the disparity-map writer.

## Interface
- CHUNKS, 16, number of 4-candidate words per pixel (range 1..64); disparity range = 4*CHUNKS.
- DW, 8, disparity output width; must satisfy 2^DW > 4*CHUNKS-1.
- MAX_COST, 5'd24, confidence threshold (used only with DISP_COST_CHECK_EN).
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  packed word present.
- in_ready  output  1  block accepts word this cycle.
- in_sof  input  1  word is chunk 0 of a new pixel (resynchronises counter).
- in_data  input  9  packed word: [8:7] reserved zero, [6:2] min cost, [1] in-pair select, [0] pair select.
- out_valid  output  1  disparity result held.
- out_ready  input  1  downstream accepts result.
- disp_out  output  DW  winning disparity.
- cost_out  output  5  winning cost.

## Operation
- Beat accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- Decode: cost = in_data[6:2]; local index = {in_data[0], in_data[1]}. Mapping: [1:0] of 00→0, 10→1, 01→2, 11→3. in_data[8:7] ignored.
- Candidate disparity = chunk_cnt*4 + local index, computed at width DW.
- chunk_cnt counts 0..CHUNKS-1. It is forced to 0 for a beat with in_sof=1, increments on each accepted beat, and wraps to 0 after the CHUNKS-1 beat.
- States:
  - IDLE: the next accepted beat loads best_cost/best_disp unconditionally and moves to ACC, or goes straight to emit if CHUNKS=1.
  - ACC: on each accepted beat, replace the best only if cost < best_cost (strict, so ties keep the lower disparity).
  - On the beat with chunk_cnt==CHUNKS-1: the final compare result (including that beat) loads the output register, sets out_valid, and the FSM returns to IDLE.
- An in_sof beat in ACC aborts the partial pixel without output; that beat starts a new pixel as in IDLE.
- Output register holds until out_valid && out_ready. A new last-beat may load in the same cycle that the old result drains.

## Timing
- Reset values:
  - out_valid=0, disp_out=0, cost_out=0.
  - chunk_cnt=0, best_cost=5'h1F, best_disp=0, FSM=IDLE.
  - in_ready=1 out of reset.
- Latency: the last chunk is accepted at edge n; out_valid and the result are visible after edge n (one register stage).
- Throughput: one word per cycle while out_ready=1; one pixel per CHUNKS cycles.
- Backpressure: out_valid=1 with out_ready=0 drops in_ready; the accumulator and counter freeze.
- Reset asserted mid-pixel discards partial state and any held result immediately.

## Configuration
- DISP_COST_CHECK_EN defined:
  - If the final cost > MAX_COST, disp_out is forced to all ones (invalid marker); cost_out still carries the actual cost.
  - 4*CHUNKS-1 must be less than 2^DW-1.
- Undefined: no threshold check; MAX_COST is unused.

## Test plan
- Reset: assert rst=0 mid-stream → out_valid=0, in_ready=1, outputs 0; after release, first pixel decodes correctly.
- CHUNKS=4, words 0x{cost 20,idx 2}, {9,idx 1}, {9,idx 3}, {15,idx 0} → disp_out=5, cost_out=9 (tie keeps chunk 1), one cycle after the 4th beat.
- Index encoding: single chunk with in_data[1:0]=01 and cost 3 → disp_out=2. With in_data[1:0]=10 → disp_out=1.
- Backpressure: hold out_ready=0 while the next pixel streams → in_ready=0, the first result is stable. Release → result drains, streaming resumes, no word lost.
- in_sof after 2 beats of a 4-chunk pixel → no output for the aborted pixel; next result covers the 4 beats starting at the sof beat.
- With DISP_COST_CHECK_EN, MAX_COST=24, all costs 30 → disp_out=8'hFF, cost_out=30. Without the macro → disp_out=0.
